// File: rtl/fir_ctrl.sv
// Sequencing controller for the 3-way unfolded 11-tap FIR: packs serial samples
// into 3-lane frames, tracks frames in flight and swaps coefficient banks only once drained.
module fir_ctrl #(
    parameter int NB    = 8,
    parameter int NTAPS = 11,
    parameter int CNT_W = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          S_VALID,
    input  logic [NB-1:0] S_DATA,
    output logic          S_READY,
    input  logic          FLUSH,
    input  logic          CFG_WE,
    input  logic [3:0]    CFG_ADDR,
    input  logic [NB-1:0] CFG_DATA,
    input  logic          CFG_COMMIT,
    output logic          CFG_BUSY,
    input  logic          VOUT_FIR,
    output logic [NB-1:0] DIN0,
    output logic [NB-1:0] DIN1,
    output logic [NB-1:0] DIN2,
    output logic          VIN,
    output logic [NB-1:0] H0,
    output logic [NB-1:0] H1,
    output logic [NB-1:0] H2,
    output logic [NB-1:0] H3,
    output logic [NB-1:0] H4,
    output logic [NB-1:0] H5,
    output logic [NB-1:0] H6,
    output logic [NB-1:0] H7,
    output logic [NB-1:0] H8,
    output logic [NB-1:0] H9,
    output logic [NB-1:0] H10,
    output logic          ERR
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ready_q, ready_d;
    logic               busy_q, busy_d;
    logic [1:0]         idx_q, idx_d, idx_n;
    logic [NB-1:0]      lane_q [3];
    logic [NB-1:0]      lane_d [3];
    logic [NB-1:0]      din_q [3];
    logic [NB-1:0]      din_d [3];
    logic               vin_q, vin_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic [NB-1:0]      shadow_q [NTAPS];
    logic [NB-1:0]      shadow_d [NTAPS];
    logic [NB-1:0]      h_q [NTAPS];
    logic [NB-1:0]      h_d [NTAPS];
    logic               accept;
    logic               drain_done;

    // State register plus the registered handshake flags decoded from the next state
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_RUN;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = CFG_COMMIT ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = drain_done ? ST_SWAP : ST_DRAIN;
            ST_SWAP:  state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    // Output decode, registered so S_READY has no path from any input
    always_comb begin
        ready_d = 1'b0;
        busy_d  = 1'b0;
        if (state_d == ST_RUN) begin
            ready_d = 1'b1;
            busy_d  = 1'b0;
        end else begin
            ready_d = 1'b0;
            busy_d  = 1'b1;
        end
    end

    // Packing, frame issue, in-flight accounting and coefficient banks
    always_comb begin
        accept   = S_VALID && ready_q;
        lane_d   = lane_q;
        din_d    = din_q;
        vin_d    = 1'b0;
        idx_d    = idx_q;
        idx_n    = idx_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        shadow_d = shadow_q;
        h_d      = h_q;

        if (accept) begin
            case (idx_q)
                2'd0:    lane_d[0] = S_DATA;
                2'd1:    lane_d[1] = S_DATA;
                2'd2:    lane_d[2] = S_DATA;
                default: lane_d[0] = lane_q[0];
            endcase
            idx_n = idx_q + 2'd1;
        end else begin
            idx_n = idx_q;
        end

        if (idx_n == 2'd3) begin
            din_d = lane_d;
            vin_d = 1'b1;
            idx_d = 2'd0;
        end else if (FLUSH && (state_q == ST_RUN) && (idx_n != 2'd0)) begin
            // A partial frame has at most two filled lanes; the rest are zero-padded
            din_d[0] = lane_d[0];
            din_d[1] = (idx_n >= 2'd2) ? lane_d[1] : {NB{1'b0}};
            din_d[2] = {NB{1'b0}};
            vin_d    = 1'b1;
            idx_d    = 2'd0;
        end else begin
            idx_d = idx_n;
        end

        case ({vin_q, VOUT_FIR})
            2'b10:   cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            2'b01:   cnt_d = (cnt_q == {CNT_W{1'b0}}) ? {CNT_W{1'b0}}
                                                      : cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            default: cnt_d = cnt_q;
        endcase

        if (VOUT_FIR && (cnt_q == {CNT_W{1'b0}})) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        // Looking at the post-update count lets the last VOUT_FIR itself release DRAIN
        drain_done = (cnt_d == {CNT_W{1'b0}}) && !vin_q;

        if (CFG_WE && (state_q == ST_RUN) && !busy_q && (CFG_ADDR <= 4'(NTAPS - 1))) begin
            shadow_d[CFG_ADDR] = CFG_DATA;
        end else begin
            shadow_d = shadow_q;
        end

        if (state_q == ST_SWAP) begin
            h_d = shadow_q;
        end else begin
            h_d = h_q;
        end
    end

    // Datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            idx_q    <= 2'd0;
            lane_q   <= '{default: '0};
            din_q    <= '{default: '0};
            vin_q    <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            err_q    <= 1'b0;
            shadow_q <= '{default: '0};
            h_q      <= '{default: '0};
        end else begin
            idx_q    <= idx_d;
            lane_q   <= lane_d;
            din_q    <= din_d;
            vin_q    <= vin_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            shadow_q <= shadow_d;
            h_q      <= h_d;
        end
    end

    assign S_READY  = ready_q;
    assign CFG_BUSY = busy_q;
    assign DIN0     = din_q[0];
    assign DIN1     = din_q[1];
    assign DIN2     = din_q[2];
    assign VIN      = vin_q;
    assign ERR      = err_q;
    assign H0       = h_q[0];
    assign H1       = h_q[1];
    assign H2       = h_q[2];
    assign H3       = h_q[3];
    assign H4       = h_q[4];
    assign H5       = h_q[5];
    assign H6       = h_q[6];
    assign H7       = h_q[7];
    assign H8       = h_q[8];
    assign H9       = h_q[9];
    assign H10      = h_q[10];

endmodule

// File: doc/fir_ctrl.md
# fir_ctrl

Sequencing controller for the 3-way unfolded 11-tap FIR (`myfir`).
- Packs a serial sample stream into 3-sample parallel frames (`DIN0..DIN2` + `VIN`).
- Owns the double-buffered coefficient bank driving `H0..H10`.
- Tracks frames in flight through the filter, so a coefficient update is applied only after the pipeline drains. No output frame ever mixes old and new coefficients.
- Sits between the sample source / configuration bus and `myfir`.

## Interface
- `NB`, 8, sample and coefficient width
- `NTAPS`, 11, number of coefficients (fixed by `myfir`)
- `CNT_W`, 4, width of the in-flight frame counter
- `CLK`  in  1  clock, rising edge
- `RST`  in  1  reset, asynchronous, active-high
- `S_VALID`  in  1  serial sample valid
- `S_DATA`  in  NB  serial sample
- `S_READY`  out  1  sample accepted when `S_VALID && S_READY`
- `FLUSH`  in  1  zero-pad and issue the current partial frame
- `CFG_WE`  in  1  shadow coefficient write strobe
- `CFG_ADDR`  in  4  shadow index 0..10; 11..15 ignored
- `CFG_DATA`  in  NB  shadow coefficient value
- `CFG_COMMIT`  in  1  request shadow→active swap
- `CFG_BUSY`  out  1  commit in progress
- `VOUT_FIR`  in  1  `VOUT` from `myfir`, one pulse per completed frame
- `DIN0`, `DIN1`, `DIN2`  out  NB each  frame to `myfir`; `DIN0` is the oldest sample
- `VIN`  out  1  one-cycle frame valid to `myfir`
- `H0`..`H10`  out  NB each  active coefficients
- `ERR`  out  1  sticky: `VOUT_FIR` seen with zero frames in flight

## Operation
- Reset values:
  - state RUN; lane index 0; in-flight count 0.
  - `DIN0..2`, `VIN`, `H0..H10`, all shadow registers, `CFG_BUSY`, `ERR` = 0.
  - `S_READY` = 0 while `RST` is high, 1 from the first cycle after release.
- States:
  - RUN: `S_READY = 1`.
  - DRAIN: `S_READY = 0`, `CFG_BUSY = 1`.
  - SWAP: `S_READY = 0`, `CFG_BUSY = 1`.
- Packing:
  - Each accepted sample is stored in lane `idx` (0, 1, 2), then `idx` increments.
  - Accepting lane 2 wraps `idx` to 0 and registers all three lanes to `DIN0..2`, with `VIN = 1` on the next cycle.
  - `DIN0..2` hold their value between `VIN` pulses.
- FLUSH (RUN only):
  - Takes effect after that cycle's accept.
  - If `idx > 0` afterwards, the unfilled lanes become 0, the frame is issued as above, and `idx` returns to 0.
  - If `idx == 0`, FLUSH is a no-op.
- In-flight counter:
  - +1 on each cycle with `VIN = 1`; −1 on `VOUT_FIR`; both in the same cycle leaves it unchanged.
  - `VOUT_FIR` at count 0 leaves the count at 0 and sets `ERR` until reset.
  - Wraps at 2^CNT_W; the user must keep frames in flight below 2^CNT_W.
- Config writes:
  - `CFG_WE` with `CFG_ADDR <= 10` writes shadow[`CFG_ADDR`] in RUN only.
  - Writes are ignored while `CFG_BUSY = 1`.
  - A write and a commit in the same cycle: the write lands first and is included in the swap.
- Commit:
  - `CFG_COMMIT` in RUN → DRAIN.
  - DRAIN → SWAP when in-flight count == 0 and `VIN == 0` in that cycle.
  - SWAP copies shadow to `H0..H10` and returns to RUN.
  - `CFG_COMMIT` outside RUN is ignored.
- Partial frames during commit: lanes already filled are retained across DRAIN/SWAP, and packing resumes at the same `idx`.
- The filter's internal delay line is not cleared; the first frames after a swap use the new `H` on older samples by design.

## Timing
- Sample to `VIN`: third sample accepted at cycle t → `VIN = 1` and new `DIN0..2` at t+1.
- FLUSH at t with `idx > 0` → `VIN` at t+1.
- `CFG_COMMIT` at t (RUN):
  - t+1: DRAIN, `S_READY = 0`, `CFG_BUSY = 1`. A frame completed at t still issues `VIN` at t+1.
  - Empty pipeline: DRAIN at t+1, SWAP at t+2, RUN at t+3.
  - New `H` values, `S_READY = 1` and `CFG_BUSY = 0` all appear at t+3.
- `H0..H10` change only on the SWAP→RUN clock edge.
- `RST` asserted mid-operation:
  - All state clears immediately (asynchronous).
  - Pending frames are lost and the in-flight count returns to 0.
- `S_READY` is decoded from registered state only; there is no combinational path from any input.

## Test plan
- Reset, then stream samples 1..6 continuously → `VIN` pulses 1 cycle after the 3rd and 6th accepts. Frames are (`DIN0`, `DIN1`, `DIN2`) = (1,2,3) then (4,5,6).
- Accept 7 and 8, then pulse FLUSH → next cycle `VIN = 1` with (7,8,0) and `idx = 0`. FLUSH at `idx = 0` produces no `VIN`.
- Write shadow[i] = i+1 for i = 0..10, then commit with 2 frames in flight (`VOUT_FIR` returning 3 and 5 cycles later):
  - `S_READY` and `CFG_BUSY` switch at t+1.
  - `H` keeps its old value until both `VOUT_FIR` pulses have arrived.
  - Then `H0..H10` = 1..11, visible 2 cycles after the last `VOUT_FIR`.
- Commit after accepting 1 sample (value 9) → after RUN resumes, samples 10 and 11 complete frame (9,10,11).
- Commit with `CFG_WE` to addr 3 = 0x55 in the same cycle → `H3 = 0x55` after the swap. A write during DRAIN does not change the shadow.
- `VOUT_FIR` pulse with 0 in flight → `ERR = 1` and stays high; count stays 0. Assert `RST` mid-DRAIN → `H` = 0, state RUN, `ERR = 0`.
